// File: rtl/jio_pkg.sv
// Shared constants and types for the jio_tty I/O controller.
// Device addresses, drain FSM states and status bit positions.
package jio_pkg;

  localparam logic [7:0] TTY_ADDR_DEF  = 8'd0;
  localparam logic [7:0] KBD_ADDR_DEF  = 8'd1;
  localparam logic [7:0] STAT_ADDR_DEF = 8'd2;

  typedef enum logic {
    IDLE,
    HOLD
  } drain_e;

  localparam int ST_KBD    = 0;
  localparam int ST_NEMPTY = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_OVF    = 3;

endpackage

// File: rtl/jfifo.sv
// Small synchronous FIFO with combinational head output.
// Push and pop in the same cycle both succeed, even when full.
module jfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             din_i,
  output logic [W-1:0]             dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/jio_tty.sv
// Clocked TTY / keyboard / status controller on the CPU I/O lines.
// Buffers TTY bytes and shows each on the display for a hold window.
module jio_tty
  import jio_pkg::*;
#(
  parameter logic [7:0] TTY_ADDR    = TTY_ADDR_DEF,
  parameter logic [7:0] KBD_ADDR    = KBD_ADDR_DEF,
  parameter logic [7:0] STAT_ADDR   = STAT_ADDR_DEF,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         HOLD_CYCLES = 50_000_000
) (
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       io_s,
  input  logic       io_e,
  input  logic       io_da,
  input  logic       io_io,
  input  logic [7:0] bus_in,
  output logic [7:0] bus_out,
  input  logic [7:0] sw,
  input  logic       key,
  output logic [7:0] disp,
  output logic       disp_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic addr_s, wr_s, rd_s;
  logic addr_q, wr_q, rd_q, key_q, arm_q;
  logic addr_re, wr_re, key_re, rd_fe;

  logic [7:0] dev_sel_q;
  logic [7:0] kbd_data_q;
  logic       kbd_valid_q;
  logic       ovf_q;

  logic          push, pop;
  logic          f_full, f_empty;
  logic [7:0]    f_head;
  logic [AW:0]   f_count;
  logic [7:0]    stat;

  drain_e        state_q;
  logic [CW-1:0] hold_q;
  logic [7:0]    disp_q;
  logic          busy_q;

  assign addr_s = io_s & io_io & io_da;
  assign wr_s   = io_s & io_io & ~io_da;
  assign rd_s   = io_e & ~io_io & ~io_da;

  // arm_q masks strobes that were already high when reset released
  assign addr_re = arm_q & addr_s & ~addr_q;
  assign wr_re   = arm_q & wr_s & ~wr_q;
  assign key_re  = arm_q & key & ~key_q;
  assign rd_fe   = arm_q & rd_q & ~rd_s;

  assign push = wr_re & (dev_sel_q == TTY_ADDR);
  assign pop  = (state_q == IDLE) & ~f_empty;

  jfifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_n_i (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus_in),
    .dout_o  (f_head),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (f_count)
  );

  always_comb begin
    stat            = '0;
    stat[ST_KBD]    = kbd_valid_q;
    stat[ST_NEMPTY] = (f_count != '0);
    stat[ST_FULL]   = (f_count == (AW+1)'(FIFO_DEPTH));
    stat[ST_OVF]    = ovf_q;
  end

  always_comb begin
    bus_out = '0;
    if (rd_s) begin
      unique case (1'b1)
        (dev_sel_q == KBD_ADDR):
          bus_out = kbd_valid_q ? kbd_data_q : 8'h00;
        (dev_sel_q == STAT_ADDR):
          bus_out = stat;
        default:
          bus_out = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      addr_q      <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      key_q       <= 1'b0;
      arm_q       <= 1'b0;
      dev_sel_q   <= '0;
      kbd_data_q  <= '0;
      kbd_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      addr_q <= addr_s;
      wr_q   <= wr_s;
      rd_q   <= rd_s;
      key_q  <= key;
      arm_q  <= 1'b1;
      if (addr_re) dev_sel_q <= bus_in;
      if (key_re) begin
        kbd_data_q  <= sw;
        kbd_valid_q <= 1'b1;
      end else if (rd_fe && dev_sel_q == KBD_ADDR) begin
        kbd_valid_q <= 1'b0;
      end
      if (push && f_full && !pop) begin
        ovf_q <= 1'b1;
      end else if (rd_fe && dev_sel_q == STAT_ADDR) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!f_empty) begin
            disp_q  <= f_head;
            hold_q  <= CW'(HOLD_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hold_q <= hold_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign disp      = disp_q;
  assign disp_busy = busy_q;

endmodule

// File: doc/jio_tty.md
# jio_tty

Clocked I/O device controller that sits directly downstream of the CPU's I/O control lines (io_s/io_e/io_da/io_io) and replaces the rudimentary combinational TTY latch. It tracks the selected device address and buffers TTY output bytes in a small FIFO. It drains that FIFO to the seven-segment display at a human-readable rate and serves a switch-based keyboard plus a status register back onto the CPU bus.

## Interface
Parameters:
- TTY_ADDR, 8'd0, device address of TTY output
- KBD_ADDR, 8'd1, device address of keyboard input
- STAT_ADDR, 8'd2, device address of status register
- FIFO_DEPTH, 4, TTY FIFO entries (power of 2, ≥2)
- HOLD_CYCLES, 50_000_000, CLK cycles each byte is held on the display (≥1)

Ports:
- CLK  in  1  system clock; sole clock
- reset_n  in  1  synchronous, active-low reset
- io_s  in  1  CPU I/O set strobe (level)
- io_e  in  1  CPU I/O enable strobe (level)
- io_da  in  1  1 = address phase, 0 = data phase
- io_io  in  1  1 = output (CPU→device), 0 = input
- bus_in  in  8  CPU bus value
- bus_out  out  8  value driven onto the wired-OR CPU bus; 0 when not reading
- sw  in  8  keyboard data switches
- key  in  1  keyboard commit button (level, already debounced)
- disp  out  8  byte to seven_seg_dec
- disp_busy  out  1  high while a byte is in its hold window

## Operation
- CPU strobes are levels; all strobes and key are registered once, and actions fire on rising edge (x & !x_q), at most once per strobe pulse.
- Address select: rising edge of io_s&io_io&io_da → dev_sel <= bus_in.
- TTY write: rising edge of io_s&io_io&!io_da with dev_sel==TTY_ADDR → push bus_in. Push when full (and no same-cycle pop) → byte dropped, overflow <= 1 (sticky).
- Keyboard: rising edge of key → kbd_data <= sw, kbd_valid <= 1 (overwrites unread data).
- Reads (combinational): io_e&!io_io&!io_da drives bus_out = kbd_valid ? kbd_data : 0 if dev_sel==KBD_ADDR; {4'b0, overflow, full, !empty, kbd_valid} if dev_sel==STAT_ADDR; else 0. bus_out is 0 whenever read condition is false.
- Falling edge of the read condition: KBD read clears kbd_valid; STAT read clears overflow. Same-cycle key edge wins over clear (kbd_valid stays 1).
- Drain FSM, states IDLE, HOLD:
  - IDLE & !empty → pop, disp <= head, hold_cnt <= HOLD_CYCLES-1, → HOLD.
  - HOLD & hold_cnt==0 → IDLE; else hold_cnt decrements.
  - disp keeps last byte after HOLD ends; disp_busy = (state==HOLD).
- FIFO: pointers log2(FIFO_DEPTH) bits wrapping naturally; count log2(FIFO_DEPTH)+1 bits. Simultaneous push+pop: both take effect, count unchanged, accepted even when full.
- Reset (any time, including mid-HOLD or mid-strobe): dev_sel=0, FIFO empty, overflow=0, kbd_data=0, kbd_valid=0, disp=0, disp_busy=0, state IDLE, edge registers=0. A strobe already high when reset releases produces no action; the edge registers are cleared only by reset and load the live strobe level normally from the cycle reset releases.

## Timing
- Push: edge detected and byte written at the same posedge P; count visible after P.
- First display: IDLE at P+1 pops; disp valid after P+1. Push-to-display latency = 2 edges.
- Back-to-back drain: one byte per HOLD_CYCLES+1 cycles.
- Status reflects FIFO state registered at the previous edge; bus_out has zero-cycle latency from strobe and dev_sel.

## Structure
- Package jio_pkg: default device address constants, drain state enum (IDLE, HOLD), status bit index constants.
- Sub-module jfifo (parameterised synchronous FIFO: push, pop, din, dout, full, empty, count) instantiated once; edge detectors, dev_sel, keyboard, status, and drain FSM live in jio_tty.

## Test plan
- Reset, then select TTY (address 0), write 8'h2A, HOLD_CYCLES=4 → disp=8'h2A two edges after the write edge, disp_busy high 4 cycles, then low; disp stays 8'h2A.
- With FIFO_DEPTH=4 and HOLD_CYCLES=8, write 6 bytes back-to-back → first byte popped, next 4 buffered, 6th dropped, status reads 8'b0000_1110; STAT read end clears bit 3; display sequence matches first 5 bytes, spaced 9 cycles apart.
- Select KBD (1), sw=8'h55, pulse key → read returns 8'h55; a second read returns 8'h00; status bit 0 tracks.
- Address-select then data write to device 7 → FIFO unchanged, disp unchanged, bus_out stays 0.
- Push while full in the same cycle FSM pops → byte accepted, overflow stays 0.
- Assert reset_n=0 mid-HOLD with 3 bytes queued → next cycle all outputs zero and FIFO empty; io_s held high across reset release → no push.
